// File: rtl/cdc_pkg.sv
// Shared types and defaults for the CDC handshake source.
// Used by cdc_sync_bit and cdc_handshake_source.
package cdc_pkg;

    localparam int DEF_SYNC_DEPTH     = 3;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } cdc_state_t;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer, async active-low reset to 0.
// The output is the last stage of the chain.
module cdc_sync_bit #(
    parameter int DEPTH = cdc_pkg::DEF_SYNC_DEPTH
) (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_chain;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_chain[DEPTH-1];

endmodule

// File: rtl/cdc_handshake_source.sv
// Source side of a 2-phase req/ack CDC handshake with a held payload bus.
// Optional sticky ack-timeout flag enabled by macro CDC_SRC_TIMEOUT_EN.
//
//  state       | meaning
//  ST_IDLE     | no transfer outstanding; accepts when ack_s matches io_req
//  ST_WAIT_ACK | io_req toggled, io_data held, waiting for ack_s to match
module cdc_handshake_source
    import cdc_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int SYNC_DEPTH     = DEF_SYNC_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_enq_valid,
    output logic             io_enq_ready,
    input  logic [WIDTH-1:0] io_enq_bits,
    output logic             io_req,
    output logic [WIDTH-1:0] io_data,
    input  logic             io_ack,
    output logic             io_busy
`ifdef CDC_SRC_TIMEOUT_EN
    ,
    output logic             io_timeout
`endif
);

    localparam bit PARAMS_OK = (WIDTH >= 1) && (SYNC_DEPTH >= 2) && (TIMEOUT_CYCLES >= 1);

    if (!PARAMS_OK) begin : g_illegal_params
    end

    cdc_state_t       r_state;
    cdc_state_t       w_state_nxt;
    logic             r_req;
    logic [WIDTH-1:0] r_data;
    logic             w_ack_s;
    logic             w_ack_match;
    logic             w_ready;
    logic             w_accept;

    cdc_sync_bit #(
        .DEPTH (SYNC_DEPTH)
    ) u_ack_sync (
        .clock (clock),
        .reset (reset),
        .i_d   (io_ack),
        .o_q   (w_ack_s)
    );

    // Ready depends only on flops so there is no valid->ready combinational path.
    always_comb begin
        w_ack_match = (w_ack_s == r_req);
        w_ready     = (r_state == ST_IDLE) && w_ack_match;
        w_accept    = io_enq_valid && w_ready;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_accept)    w_state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: if (w_ack_match) w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_req  <= ~r_req;
                r_data <= io_enq_bits;
            end
        end
    end

    assign io_enq_ready = w_ready;
    assign io_req       = r_req;
    assign io_data      = r_data;
    assign io_busy      = (r_state == ST_WAIT_ACK);

`ifdef CDC_SRC_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // Flag is set on the same edge the counter reaches TIMEOUT_CYCLES.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == ST_WAIT_ACK) begin
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_cnt >= CNT_LAST) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign io_timeout = r_timeout;
`endif

endmodule
